// File: rtl/prod_accum.sv
// prod_accum: sums N_TERMS signed 64-bit products, one per rising edge of prod_valid.
// Holds the completed sum with acc_valid until clr or reset.
`default_nettype none

module prod_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 66
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic [63:0]      prod,
  input  logic             prod_valid,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  output logic [7:0]       term_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_ext;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             prev_valid_q;
  logic             capture;

  generate
    if (ACC_W > 64) begin : g_sext
      assign prod_ext = {{(ACC_W-64){prod[63]}}, prod};
    end else begin : g_nosext
      assign prod_ext = prod;
    end
  endgenerate

  // A level held high for many cycles counts as a single term.
  assign capture = prod_valid & ~prev_valid_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (capture && state_q != ST_DONE) begin
      acc_d = acc_q + prod_ext;
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == LAST_CNT) begin
        state_d = ST_DONE;
        valid_d = 1'b1;
      end else begin
        state_d = ST_ACC;
      end
    end
    busy_d = (state_d == ST_ACC);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      prev_valid_q <= prod_valid;
    end
  end

  assign acc       = acc_q;
  assign acc_valid = valid_q;
  assign term_cnt  = cnt_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: per-edge expectations from a term-list model,
// popped and compared by an independent monitor just after each rising edge.
`default_nettype none

module tb_prod_accum;

  localparam int N = 4;
  localparam int W = 66;

  logic          CLK;
  logic          reset;
  logic          clr;
  logic [63:0]   prod;
  logic          prod_valid;
  logic [W-1:0]  acc;
  logic          acc_valid;
  logic [7:0]    term_cnt;
  logic          busy;

  prod_accum #(.N_TERMS(N), .ACC_W(W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .clr       (clr),
    .prod      (prod),
    .prod_valid(prod_valid),
    .acc       (acc),
    .acc_valid (acc_valid),
    .term_cnt  (term_cnt),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] acc;
    logic [7:0]   cnt;
    logic         valid;
    logic         busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_terms[$];
  logic        m_prev;
  int          n_tests;
  int          n_fail;

  // Reference: the accepted terms themselves; outputs derive from their count and sum.
  function automatic exp_t model_expect();
    exp_t e;
    logic [W-1:0] s;
    s = '0;
    foreach (m_terms[i]) s = s + {{(W-64){m_terms[i][63]}}, m_terms[i]};
    e.acc   = s;
    e.cnt   = 8'(m_terms.size());
    e.valid = (m_terms.size() == N);
    e.busy  = (m_terms.size() > 0) && (m_terms.size() < N);
    return e;
  endfunction

  task automatic step(input logic c, input logic v, input logic [63:0] p);
    @(negedge CLK);
    clr        = c;
    prod_valid = v;
    prod       = p;
    if (c) m_terms.delete();
    else if (v && !m_prev && m_terms.size() < N) m_terms.push_back(p);
    m_prev = v;
    exp_q.push_back(model_expect());
    @(posedge CLK);
  endtask

  task automatic pulse(input logic [63:0] p);
    step(1'b0, 1'b1, p);
    step(1'b0, 1'b0, p);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (acc !== '0 || term_cnt !== 8'd0 || acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: acc=%h cnt=%0d valid=%b busy=%b, required all zero",
               name, acc, term_cnt, acc_valid, busy);
    end
  endtask

  // Monitor: one expectation per rising edge while the driver is issuing stimulus.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (acc !== e.acc || term_cnt !== e.cnt || acc_valid !== e.valid || busy !== e.busy) begin
          n_fail++;
          $display("FAIL cycle@%0t: acc=%h cnt=%0d valid=%b busy=%b, required acc=%h cnt=%0d valid=%b busy=%b",
                   $time, acc, term_cnt, acc_valid, busy, e.acc, e.cnt, e.valid, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_prev     = 1'b0;
    reset      = 1'b0;
    clr        = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    #1;
    check_zero("reset_state");
    repeat (2) @(posedge CLK);
    #3 reset = 1'b1;

    // Balanced products cancel to zero.
    pulse(64'sd2700); pulse(-64'sd2700); pulse(-64'sd2700); pulse(64'sd2700);
    step(1'b1, 1'b0, '0);

    // Largest positive product four times must not wrap.
    repeat (4) pulse(64'h4000_0000_0000_0000);
    step(1'b1, 1'b0, '0);

    // A long level counts once.
    repeat (10) step(1'b0, 1'b1, 64'sd2700);
    step(1'b0, 1'b0, '0);
    pulse(-64'sd30);
    step(1'b1, 1'b0, '0);

    // clr beats a simultaneous capture.
    pulse(64'sd100); pulse(64'sd100);
    step(1'b1, 1'b1, 64'sd900);
    step(1'b0, 1'b0, '0);
    pulse(64'sd5);
    step(1'b1, 1'b0, '0);

    // Asynchronous reset mid-accumulation, released with prod_valid already high.
    pulse(64'sd11); pulse(64'sd22); pulse(64'sd33);
    @(posedge CLK);
    #3 reset = 1'b0;
    #1 check_zero("async_reset");
    m_terms.delete();
    m_prev     = 1'b0;
    prod_valid = 1'b1;
    prod       = 64'sd2700;
    repeat (2) @(posedge CLK);
    #3 reset = 1'b1;
    repeat (3) step(1'b0, 1'b1, 64'sd2700);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);

    // Captures in DONE are ignored until clr.
    pulse(64'sd1); pulse(64'sd2); pulse(64'sd3); pulse(64'sd4);
    repeat (3) pulse(64'sd123);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Randomized traffic including extreme operands and occasional clr.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] p;
      case ($urandom_range(0, 4))
        0: p = 64'h8000_0000_0000_0000;
        1: p = 64'h4000_0000_0000_0000;
        2: p = 64'(-$signed(64'($urandom_range(0, 1000))));
        default: p = {$urandom, $urandom};
      endcase
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, p);
    end

    repeat (2) @(posedge CLK);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
